// File: rtl/sm_target_packer.sv
// Packs one ID header plus an ASCII nucleotide stream into a {ID, LENGTH, TARGET} feeder word.
// Holds a single record and presents it to the feeder with a registered one-cycle load pulse.
module sm_target_packer #(
  parameter int unsigned TARGET_LENGTH = 128,
  parameter int unsigned LEN_WIDTH     = 12,
  parameter int unsigned ID_WIDTH      = 48,
  parameter int unsigned IN_WIDTH      = ID_WIDTH + LEN_WIDTH + 2 * TARGET_LENGTH,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hdr_valid,
  input  logic [ID_WIDTH-1:0]  hdr_id,
  output logic                 hdr_ready,
  input  logic                 in_valid,
  input  logic [7:0]           in_char,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 full,
  output logic                 ld,
  output logic [IN_WIDTH-1:0]  feed_out,
  output logic                 err_char,
  output logic                 err_ovf,
  output logic [CNT_WIDTH-1:0] rec_count
);

  typedef enum logic [1:0] {StIdle, StCollect, StPending, StLoad} state_e;

  state_e                     r_state;
  logic [ID_WIDTH-1:0]        r_id;
  logic [LEN_WIDTH-1:0]       r_len;
  logic [2*TARGET_LENGTH-1:0] r_target;
  logic                       r_err_char;
  logic                       r_err_ovf;
  logic                       r_ld;
  logic [CNT_WIDTH-1:0]       r_count;

  logic [1:0] w_code;
  logic       w_bad;
  logic       w_room;
  logic       w_hdr_acc;
  logic       w_chr_acc;

  always_comb begin
    w_code = 2'b00;
    w_bad  = 1'b0;
    unique case (in_char)
      8'h41, 8'h61: w_code = 2'b00;
      8'h43, 8'h63: w_code = 2'b01;
      8'h47, 8'h67: w_code = 2'b10;
      8'h54, 8'h74: w_code = 2'b11;
      default:      w_bad  = 1'b1;
    endcase
  end

  // Once the record is full, further bases are swallowed and only flag overflow.
  assign w_room    = (r_len < LEN_WIDTH'(TARGET_LENGTH));
  assign w_hdr_acc = hdr_valid & hdr_ready;
  assign w_chr_acc = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_id       <= '0;
      r_len      <= '0;
      r_target   <= '0;
      r_err_char <= 1'b0;
      r_err_ovf  <= 1'b0;
      r_ld       <= 1'b0;
      r_count    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_ld <= 1'b0;
          if (w_hdr_acc) begin
            r_id       <= hdr_id;
            r_len      <= '0;
            r_target   <= '0;
            r_err_char <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_state    <= StCollect;
          end
        end
        StCollect: begin
          if (w_chr_acc) begin
            if (w_bad) begin
              r_err_char <= 1'b1;
            end
            if (w_room) begin
              for (int unsigned k = 0; k < TARGET_LENGTH; k++) begin
                if (r_len == LEN_WIDTH'(k)) begin
                  r_target[2*k +: 2] <= w_code;
                end
              end
              r_len <= r_len + LEN_WIDTH'(1);
            end else begin
              r_err_ovf <= 1'b1;
            end
            if (in_last) begin
              r_state <= StPending;
            end
          end
        end
        StPending: begin
          // full is sampled here only; ld is the flop, never a combinational function of full.
          if (!full) begin
            r_ld    <= 1'b1;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          r_ld    <= 1'b0;
          r_count <= r_count + CNT_WIDTH'(1);
          r_state <= StIdle;
        end
        default: begin
          r_ld    <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign hdr_ready = (r_state == StIdle);
  assign in_ready  = (r_state == StCollect);
  assign ld        = r_ld;
  assign feed_out  = {r_id, r_len, r_target};
  assign err_char  = r_err_char;
  assign err_ovf   = r_err_ovf;
  assign rec_count = r_count;

endmodule

// File: tb/tb_sm_target_packer.sv
// Bench for sm_target_packer: record-level reference model checked every cycle, plus
// directed scenarios with literal expectations. A second instance exercises a 2-bit counter.
module tb_sm_target_packer;

  localparam int TL  = 128;
  localparam int LW  = 12;
  localparam int IDW = 48;
  localparam int IW  = IDW + LW + 2 * TL;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           hdr_valid = 1'b0;
  logic [IDW-1:0] hdr_id = '0;
  logic           in_valid = 1'b0;
  logic [7:0]     in_char = 8'h00;
  logic           in_last = 1'b0;
  logic           full = 1'b0;

  logic          hdr_ready, in_ready, ld, err_char, err_ovf;
  logic [IW-1:0] feed_out;
  logic [CW-1:0] rec_count;

  logic          hdr_ready_w, in_ready_w, ld_w, err_char_w, err_ovf_w;
  logic [IW-1:0] feed_out_w;
  logic [1:0]    rec_count_w;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sm_target_packer dut (
    .clk(clk), .rst(rst), .hdr_valid(hdr_valid), .hdr_id(hdr_id), .hdr_ready(hdr_ready),
    .in_valid(in_valid), .in_char(in_char), .in_last(in_last), .in_ready(in_ready),
    .full(full), .ld(ld), .feed_out(feed_out), .err_char(err_char), .err_ovf(err_ovf),
    .rec_count(rec_count)
  );

  sm_target_packer #(.CNT_WIDTH(2)) dut_w (
    .clk(clk), .rst(rst), .hdr_valid(hdr_valid), .hdr_id(hdr_id), .hdr_ready(hdr_ready_w),
    .in_valid(in_valid), .in_char(in_char), .in_last(in_last), .in_ready(in_ready_w),
    .full(full), .ld(ld_w), .feed_out(feed_out_w), .err_char(err_char_w),
    .err_ovf(err_ovf_w), .rec_count(rec_count_w)
  );

  task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: a record is just the list of characters accepted since the header.
  localparam int PIdle = 0, PCollect = 1, PPending = 2, PLoad = 3;
  int          m_phase = PIdle;
  logic [IDW-1:0] m_id = '0;
  logic [7:0]  m_chars[$];
  int unsigned m_count = 0;
  logic        m_armed = 1'b0;

  function automatic logic [1:0] code(input logic [7:0] c);
    case (c)
      "C", "c": return 2'd1;
      "G", "g": return 2'd2;
      "T", "t": return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

  function automatic logic is_base(input logic [7:0] c);
    return (c inside {"A", "a", "C", "c", "G", "g", "T", "t"});
  endfunction

  function automatic logic [IW-1:0] exp_feed();
    logic [2*TL-1:0] t = '0;
    int n = (m_chars.size() > TL) ? TL : m_chars.size();
    for (int k = 0; k < n; k++) t[2*k +: 2] = code(m_chars[k]);
    return {m_id, LW'(n), t};
  endfunction

  function automatic logic exp_err_char();
    foreach (m_chars[i]) if (!is_base(m_chars[i])) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_phase = PIdle;
      m_id    = '0;
      m_chars.delete();
      m_count = 0;
      m_armed = 1'b1;
    end else begin
      case (m_phase)
        PIdle: if (hdr_valid) begin
          m_id = hdr_id;
          m_chars.delete();
          m_phase = PCollect;
        end
        PCollect: if (in_valid) begin
          m_chars.push_back(in_char);
          if (in_last) m_phase = PPending;
        end
        PPending: if (!full) m_phase = PLoad;
        default: begin
          m_count++;
          m_phase = PIdle;
        end
      endcase
    end
  end

  int cyc = 0;
  int last_ld = -1;
  always @(negedge clk) begin
    if (m_armed) begin
      cyc++;
      chk("hdr_ready", hdr_ready, m_phase == PIdle);
      chk("in_ready", in_ready, m_phase == PCollect);
      chk("ld", ld, m_phase == PLoad);
      chk("feed_out", feed_out, exp_feed());
      chk("err_char", err_char, exp_err_char());
      chk("err_ovf", err_ovf, m_chars.size() > TL);
      chk("rec_count", rec_count, m_count[CW-1:0]);
      chk("w2_ld", ld_w, m_phase == PLoad);
      chk("w2_rec_count", rec_count_w, m_count[1:0]);
      if (ld) begin
        if (last_ld >= 0) chk("ld_gap_ge3", (cyc - last_ld) >= 3, 1);
        last_ld = cyc;
      end
    end
  end

  task automatic send_hdr(input logic [IDW-1:0] id);
    int g = 0;
    hdr_valid = 1'b1;
    hdr_id    = id;
    while (!hdr_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_vec++;
      n_bad++;
      $display("FAIL hdr_timeout: hdr_ready got 0 want 1");
    end
    @(negedge clk);
    hdr_valid = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c, input logic last);
    int g = 0;
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_vec++;
      n_bad++;
      $display("FAIL chr_timeout: in_ready got 0 want 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], i == s.len() - 1);
  endtask

  task automatic wait_ld();
    int g = 0;
    while (!ld && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      n_vec++;
      n_bad++;
      $display("FAIL ld_timeout: ld got 0 want 1");
    end
  endtask

  int wrap_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hdr_ready", hdr_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ld", ld, 0);
    chk("rst_rec_count", rec_count, 0);
    chk("rst_feed", feed_out, 0);
    rst = 1'b1;

    // Normal record
    send_hdr(48'h123456789ABC);
    send_str("ACGT");
    chk("norm_ld_t1", ld, 0);
    @(negedge clk);
    chk("norm_ld_t2", ld, 1);
    chk("norm_feed", feed_out, {48'h123456789ABC, 12'd4, 248'd0, 8'b11100100});
    chk("norm_errs", {err_char, err_ovf}, 0);
    @(negedge clk);
    chk("norm_ld_t3", ld, 0);
    chk("norm_count", rec_count, 1);
    chk("norm_idle", hdr_ready, 1);

    // Back-pressure
    full = 1'b1;
    send_hdr(48'h1);
    send_str("GG");
    repeat (10) begin
      chk("bp_ld", ld, 0);
      chk("bp_ready", {hdr_ready, in_ready}, 0);
      chk("bp_feed", feed_out, {48'h1, 12'd2, 252'd0, 4'b1010});
      @(negedge clk);
    end
    full = 1'b0;
    @(negedge clk);
    chk("bp_ld_after", ld, 1);
    chk("bp_feed_ld", feed_out, {48'h1, 12'd2, 252'd0, 4'b1010});
    @(negedge clk);
    chk("bp_count", rec_count, 2);

    // Invalid / lowercase
    send_hdr(48'h2);
    send_str("aNt");
    chk("inv_feed", feed_out, {48'h2, 12'd3, 250'd0, 6'b110000});
    chk("inv_err_char", err_char, 1);
    wait_ld();
    @(negedge clk);

    // Overflow (also checks err_char clears on header accept)
    send_hdr(48'h3);
    chk("inv_err_clear", err_char, 0);
    for (int i = 0; i < TL + 5; i++) send_char("C", i == TL + 4);
    chk("ovf_feed", feed_out, {48'h3, 12'd128, {64{4'h5}}});
    chk("ovf_err", {err_char, err_ovf}, 2'b01);
    wait_ld();
    @(negedge clk);
    chk("ovf_count", rec_count, 4);

    // Reset mid-record
    send_hdr(48'h4);
    send_char("A", 1'b0);
    send_char("C", 1'b0);
    send_char("G", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_count", rec_count, 0);
    chk("mid_idle", {hdr_ready, in_ready, ld}, 3'b100);
    send_hdr(48'h5);
    send_str("T");
    chk("mid_next_feed", feed_out, {48'h5, 12'd1, 254'd0, 2'b11});
    wait_ld();
    @(negedge clk);
    chk("mid_next_count", rec_count, 1);

    // Counter wrap on the 2-bit instance
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < 5; r++) begin
      send_hdr(IDW'(10 + r));
      send_str("A");
      wait_ld();
      @(negedge clk);
      chk("wrap_count", rec_count_w, wrap_exp[r]);
    end
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
